// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS core register file.
// Defaults match the architectural 32 x 32-bit register set with r0 hardwired.
package regfile_pkg;

    localparam int unsigned RF_DATA_W    = 32;
    localparam int unsigned RF_DEPTH     = 32;
    localparam int unsigned RF_ZERO_ADDR = 0;

    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] rf_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: issue sets a bit, writeback clears it.
// A same-cycle alloc to the retiring register wins, since it names a newer producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (alloc_en && (alloc_addr == ADDR_W'(r)) &&
                !((ZERO_REG != 0) && (r == RF_ZERO_ADDR))) begin
                busy_d[r] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-read-port register file with optional write-through bypass and a
// pending-write scoreboard so the hazard unit can stall on RAW directly.
module regfile_mp_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_store;
    logic              alloc_hits_wr;

    assign wr_store      = wr_en && !((ZERO_REG != 0) && (wr_addr == ZeroAddr));
    assign alloc_hits_wr = alloc_en && (alloc_addr == wr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_store) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              fwd;
        logic              fwd_clears_busy;

        assign ra      = rd_addr[p*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == ZeroAddr);
        assign fwd     = (BYPASS != 0) && wr_en && (wr_addr == ra);
        // A forwarded value is no longer pending unless a newer producer claims it now.
        assign fwd_clears_busy = fwd && !alloc_hits_wr;

        assign rd_data[p*DATA_W +: DATA_W] = is_zero ? {DATA_W{1'b0}} :
                                             fwd     ? wr_data : mem_q[ra];
        assign rd_busy[p] = is_zero ? 1'b0 :
                            fwd_clears_busy ? 1'b0 : busy_vec[ra];
    end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Bench for regfile_mp_bypass: bypassing and non-bypassing instances share stimulus
// and are compared against an array-based model of the register file and busy bits.
module tb_regfile_mp_bypass;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic           clk;
    logic           reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_b;
    logic [NR*DW-1:0] rd_data_n;
    logic [NR-1:0]  rd_busy_b;
    logic [NR-1:0]  rd_busy_n;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           alloc_en;
    logic [AW-1:0]  alloc_addr;
    logic [DP-1:0]  busy_vec_b;
    logic [DP-1:0]  busy_vec_n;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_mem [DP];
    bit            m_busy [DP];

    regfile_mp_bypass #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1),
                        .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b)
    );

    regfile_mp_bypass #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0),
                        .ZERO_REG(1)) dut_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    // Expected outputs from the model state plus the inputs currently applied.
    task automatic check_all();
        logic [DP-1:0] ebv;
        for (int r = 0; r < DP; r++) ebv[r] = m_busy[r];
        chk("busy_vec_b", 64'(busy_vec_b), 64'(ebv));
        chk("busy_vec_n", 64'(busy_vec_n), 64'(ebv));
        for (int p = 0; p < NR; p++) begin
            int a;
            logic [DW-1:0] eb, en;
            logic bb, bn;
            a = int'(rd_addr[p*AW +: AW]);
            if (a == 0) begin
                eb = '0; en = '0; bb = 1'b0; bn = 1'b0;
            end else begin
                en = m_mem[a];
                bn = m_busy[a];
                if (wr_en && int'(wr_addr) == a) begin
                    eb = wr_data;
                    bb = (alloc_en && alloc_addr == wr_addr) ? m_busy[a] : 1'b0;
                end else begin
                    eb = m_mem[a];
                    bb = m_busy[a];
                end
            end
            chk($sformatf("rd_data_b[%0d]", p), 64'(rd_data_b[p*DW +: DW]), 64'(eb));
            chk($sformatf("rd_data_n[%0d]", p), 64'(rd_data_n[p*DW +: DW]), 64'(en));
            chk($sformatf("rd_busy_b[%0d]", p), 64'(rd_busy_b[p]), 64'(bb));
            chk($sformatf("rd_busy_n[%0d]", p), 64'(rd_busy_n[p]), 64'(bn));
        end
    endtask

    task automatic mid();
        @(negedge clk);
        check_all();
    endtask

    task automatic edge_up();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < DP; r++) begin
                m_mem[r] = '0;
                m_busy[r] = 0;
            end
        end else begin
            if (wr_en) begin
                if (wr_addr != 0) m_mem[wr_addr] = wr_data;
                m_busy[wr_addr] = 0;
            end
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1;
        end
        #1;
    endtask

    task automatic cyc();
        mid();
        edge_up();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
        edge_up();
        reset = 1'b0;

        // Reset state on every address.
        for (int a = 0; a < DP; a++) begin
            set_rd(a, a);
            mid();
            chk("rst_data", 64'(rd_data_b), 64'(0));
            chk("rst_busy", 64'(rd_busy_b), 64'(0));
            chk("rst_bvec", 64'(busy_vec_b), 64'(0));
            edge_up();
        end

        // Write/readback and zero register.
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; cyc();
        wr_addr = 0; wr_data = 32'h12345678; cyc();
        wr_en = 1'b0; set_rd(5, 0); alloc_en = 1'b1; alloc_addr = 0;
        mid();
        chk("r5_read", 64'(rd_data_n[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
        chk("r0_read", 64'(rd_data_n[DW +: DW]), 64'(0));
        edge_up();
        alloc_en = 1'b0;
        mid();
        chk("r0_not_busy", 64'(busy_vec_b[0]), 64'(0));
        chk("r0_rd_busy", 64'(rd_busy_b[1]), 64'(0));
        edge_up();

        // Bypass versus stored value.
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h1; cyc();
        wr_data = 32'hA5A5A5A5; set_rd(7, 7);
        mid();
        chk("byp_both", 64'(rd_data_b), {32'hA5A5A5A5, 32'hA5A5A5A5});
        chk("nobyp_both", 64'(rd_data_n), {32'h1, 32'h1});
        edge_up();
        wr_en = 1'b0;
        mid();
        chk("nobyp_next", 64'(rd_data_n[0 +: DW]), 64'hA5A5A5A5);
        edge_up();

        // Scoreboard lifecycle on r9.
        alloc_en = 1'b1; alloc_addr = 9; set_rd(9, 9); cyc();
        alloc_en = 1'b0;
        mid();
        chk("r9_busy", 64'(rd_busy_b), 64'(2'b11));
        chk("r9_bvec", 64'(busy_vec_b[9]), 64'(1));
        edge_up();
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h55;
        mid();
        chk("r9_fwd_busy", 64'(rd_busy_b), 64'(0));
        chk("r9_fwd_data", 64'(rd_data_b[0 +: DW]), 64'h55);
        chk("r9_nobyp_busy", 64'(rd_busy_n), 64'(2'b11));
        edge_up();
        wr_en = 1'b0;
        mid();
        chk("r9_retired", 64'(busy_vec_b[9]), 64'(0));
        edge_up();

        // Simultaneous alloc and writeback on r3: alloc wins, data still lands.
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h77; alloc_en = 1'b1; alloc_addr = 3;
        set_rd(3, 3); cyc();
        wr_en = 1'b0; alloc_en = 1'b0;
        mid();
        chk("r3_bvec", 64'(busy_vec_b[3]), 64'(1));
        chk("r3_data", 64'(rd_data_n[0 +: DW]), 64'h77);
        chk("r3_busy", 64'(rd_busy_b), 64'(2'b11));
        edge_up();

        // Reset beats same-cycle writeback and alloc.
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h99; alloc_en = 1'b1; alloc_addr = 4; cyc();
        reset = 1'b1; wr_data = 32'h11; alloc_addr = 6; cyc();
        reset = 1'b0; wr_en = 1'b0; alloc_en = 1'b0; set_rd(4, 6);
        mid();
        chk("rstp_data", 64'(rd_data_b), 64'(0));
        chk("rstp_bvec_b", 64'(busy_vec_b), 64'(0));
        chk("rstp_bvec_n", 64'(busy_vec_n), 64'(0));
        edge_up();

        // Random traffic; a narrow address pool half the time forces collisions.
        for (int i = 0; i < 600; i++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            reset = ($urandom_range(0, 49) == 0);
            wr_en = ($urandom_range(0, 1) == 1);
            alloc_en = ($urandom_range(0, 9) < 4);
            wr_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
            alloc_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_data = $urandom;
            if (narrow) set_rd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else set_rd(int'($urandom_range(0, DP - 1)), int'($urandom_range(0, DP - 1)));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
